program_loader: RTL and testbench

Program loader that writes the instruction memory from a byte stream, so the 16-bit instructions later fetched and decoded by the core get there. It accepts bytes over a valid/ready handshake, reads a 10-bit word count, assembles big-endian 16-bit instruction words (opcode byte first), and writes them to consecutive instruction-RAM addresses starting at 0. It holds the core in reset while loading and releases it only after a complete, error-free load. It sits between the host/serial byte source and the write port of the instruction RAM.

---
 rtl/program_loader_if.sv | 25 ++
 rtl/program_loader.sv | 131 +++++++++++++
 tb/tb_program_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// program_loader_if
// Groups the byte-stream handshake and the instruction-RAM write port of the
// program loader.
//   iByte/iByteValid/oByteReady : byte stream; a byte moves on valid && ready
//   oWriteEnable/oAddress/oDataOut : instruction-RAM write port
// master : host side (drives bytes, observes ready and RAM writes)
// slave  : loader side
interface program_loader_if;
    logic [7:0]  iByte;
    logic        iByteValid;
    logic        oByteReady;
    logic        oWriteEnable;
    logic [9:0]  oAddress;
    logic [15:0] oDataOut;

    modport master (
        output iByte, iByteValid,
        input  oByteReady, oWriteEnable, oAddress, oDataOut
    );

    modport slave (
        input  iByte, iByteValid,
        output oByteReady, oWriteEnable, oAddress, oDataOut
    );
endinterface

// File: rtl/program_loader.sv
// program_loader
// Loads the instruction RAM from a byte stream: a 10-bit word count (high
// byte first, only bits [1:0] usable), then big-endian 16-bit words written
// to consecutive addresses from 0. Keeps the core in reset until a load
// completes without error.
// Ports:
//   Clock, Reset   : clock, synchronous active-high reset
//   iStart         : one-cycle pulse starting a load (IDLE/DONE/ERROR only)
//   bus            : byte handshake + RAM write port (slave modport)
//   oCpuReset      : core reset, low only after a successful load
//   oBusy/oDone/oError : session status
// Parameter TIMEOUT: inter-byte idle limit in cycles, 0 disables it.
module program_loader #(
    parameter int TIMEOUT = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    program_loader_if.slave  bus,
    output logic             oCpuReset,
    output logic             oBusy,
    output logic             oDone,
    output logic             oError
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, INS_HI, INS_LO, WRITE, DONE, ERROR
    } state_t;

    state_t      state, state_n;
    logic [9:0]  count, count_n;
    logic [9:0]  addr, addr_n;
    logic [15:0] word, word_n;
    logic [TW-1:0] idle;
    logic        accepting;
    logic        xfer;

    assign accepting = (state == CNT_HI) || (state == CNT_LO) ||
                       (state == INS_HI) || (state == INS_LO);
    assign xfer      = bus.iByteValid && accepting;

    always_comb begin
        state_n = state;
        count_n = count;
        addr_n  = addr;
        word_n  = word;
        case (state)
            IDLE, DONE, ERROR: begin
                if (iStart) begin
                    state_n = CNT_HI;
                    addr_n  = '0;
                end
            end
            CNT_HI: begin
                if (xfer) begin
                    // Counts above 1023 cannot be addressed: reject them.
                    if (bus.iByte[7:2] != 6'd0) begin
                        state_n = ERROR;
                    end else begin
                        count_n[9:8] = bus.iByte[1:0];
                        state_n      = CNT_LO;
                    end
                end
            end
            CNT_LO: begin
                if (xfer) begin
                    count_n[7:0] = bus.iByte;
                    state_n = ({count[9:8], bus.iByte} == 10'd0) ? DONE : INS_HI;
                end
            end
            INS_HI: begin
                if (xfer) begin
                    word_n[15:8] = bus.iByte;
                    state_n      = INS_LO;
                end
            end
            INS_LO: begin
                if (xfer) begin
                    word_n[7:0] = bus.iByte;
                    state_n     = WRITE;
                end
            end
            WRITE: begin
                if (addr == count - 10'd1) begin
                    state_n = DONE;
                end else begin
                    addr_n  = addr + 10'd1;
                    state_n = INS_HI;
                end
            end
            default: state_n = IDLE;
        endcase

        // Abort on the edge where the idle count would reach TIMEOUT.
        if (TIMEOUT > 0 && accepting && !xfer && (int'(idle) + 1 >= TIMEOUT))
            state_n = ERROR;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
            addr  <= '0;
            word  <= '0;
            idle  <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            addr  <= addr_n;
            word  <= word_n;
            if (!accepting || xfer || state_n != state)
                idle <= '0;
            else
                idle <= idle + 1'b1;
        end
    end

    assign bus.oByteReady   = accepting;
    // A reset arriving during WRITE must keep the partial session out of RAM.
    assign bus.oWriteEnable = (state == WRITE) && !Reset;
    assign bus.oAddress     = addr;
    assign bus.oDataOut     = word;

    assign oBusy     = accepting || (state == WRITE);
    assign oDone     = (state == DONE);
    assign oError    = (state == ERROR);
    assign oCpuReset = (state != DONE);

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic Clock = 1'b0;
    logic Reset;
    logic iStart;
    logic oCpuReset, oBusy, oDone, oError;

    program_loader_if bus();

    program_loader #(.TIMEOUT(8)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iStart    (iStart),
        .bus       (bus),
        .oCpuReset (oCpuReset),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oError    (oError)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Observed RAM writes: {address, data}
    logic [25:0] wq[$];
    always @(negedge Clock)
        if (bus.oWriteEnable === 1'b1) wq.push_back({bus.oAddress, bus.oDataOut});

    int pass = 0;
    int total = 0;
    int t0;

    task automatic start_load();
        bus.iByteValid = 1'b0;
        iStart = 1'b1;
        @(posedge Clock); #1;
        iStart = 1'b0;
        t0 = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        int n;
        repeat (stall) begin
            bus.iByteValid = 1'b0;
            @(posedge Clock); #1;
        end
        bus.iByte = b;
        bus.iByteValid = 1'b1;
        n = 0;
        while (bus.oByteReady !== 1'b1 && n < 50) begin
            @(posedge Clock); #1;
            n++;
        end
        total++;
        if (n >= 50) $display("FAIL send_byte_ready: ready never seen for byte %h", b);
        else pass++;
        @(posedge Clock); #1;
        bus.iByteValid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (oDone !== 1'b1 && n < 40) begin
            @(posedge Clock); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; iStart = 1'b0; bus.iByte = '0; bus.iByteValid = 1'b0;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        total++; if (oCpuReset !== 1'b1) $display("FAIL reset_cpureset: got %b want 1", oCpuReset); else pass++;
        total++; if ({oBusy, oDone, oError} !== 3'b000) $display("FAIL reset_status: got %b want 000", {oBusy, oDone, oError}); else pass++;
        total++; if ({bus.oByteReady, bus.oWriteEnable} !== 2'b00) $display("FAIL reset_hs: got %b want 00", {bus.oByteReady, bus.oWriteEnable}); else pass++;
        total++; if ({bus.oAddress, bus.oDataOut} !== 26'd0) $display("FAIL reset_bus: got %h want 0", {bus.oAddress, bus.oDataOut}); else pass++;
    endtask

    task automatic test_three_words();
        logic [7:0]  s[8] = '{8'h00, 8'h03, 8'h04, 8'h05, 8'h08, 8'h0A, 8'h0C, 8'h0F};
        logic [25:0] e[3] = '{{10'd0, 16'h0405}, {10'd1, 16'h080A}, {10'd2, 16'h0C0F}};
        int n;
        wq.delete();
        start_load();
        total++; if (oBusy !== 1'b1) $display("FAIL three_busy: got %b want 1", oBusy); else pass++;
        foreach (s[i]) send_byte(s[i], 0);
        wait_done(n);
        total++; if (cyc - t0 != 11) $display("FAIL three_latency: got %0d want 11", cyc - t0); else pass++;
        total++; if (wq.size() != 3) $display("FAIL three_nwrites: got %0d want 3", wq.size()); else pass++;
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            total++; if (wq[i] !== e[i]) $display("FAIL three_write%0d: got %h want %h", i, wq[i], e[i]); else pass++;
        end
        total++; if ({oDone, oCpuReset, oError} !== 3'b100) $display("FAIL three_final: got %b want 100", {oDone, oCpuReset, oError}); else pass++;
    endtask

    task automatic test_backpressure(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            logic [7:0]  s[$];
            logic [25:0] e[$];
            int nw, n;
            nw = $urandom_range(1, 7);
            s.push_back(8'((nw >> 8) & 3));
            s.push_back(8'(nw & 8'hFF));
            for (int i = 0; i < nw; i++) begin
                s.push_back(8'($urandom));
                s.push_back(8'($urandom));
            end
            for (int i = 0; i < nw; i++) e.push_back({10'(i), s[2 + 2*i], s[3 + 2*i]});
            wq.delete();
            start_load();
            foreach (s[i]) send_byte(s[i], $urandom_range(0, 3));
            wait_done(n);
            total++; if (oDone !== 1'b1 || oCpuReset !== 1'b0) $display("FAIL bp_done%0d: done=%b cpureset=%b want 1/0", r, oDone, oCpuReset); else pass++;
            total++; if (wq.size() != e.size()) $display("FAIL bp_nwrites%0d: got %0d want %0d", r, wq.size(), e.size()); else pass++;
            for (int i = 0; i < e.size() && i < wq.size(); i++) begin
                total++; if (wq[i] !== e[i]) $display("FAIL bp_write%0d_%0d: got %h want %h", r, i, wq[i], e[i]); else pass++;
            end
        end
    endtask

    task automatic test_zero_count();
        int n;
        wq.delete();
        start_load();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_done(n);
        total++; if ({oDone, oCpuReset} !== 2'b10) $display("FAIL zero_done: got %b want 10", {oDone, oCpuReset}); else pass++;
        total++; if (wq.size() != 0) $display("FAIL zero_nwrites: got %0d want 0", wq.size()); else pass++;
    endtask

    task automatic test_bad_count();
        int n;
        wq.delete();
        start_load();
        send_byte(8'h04, 0);
        bus.iByte = 8'h00; bus.iByteValid = 1'b1;
        repeat (3) @(posedge Clock);
        #1 bus.iByteValid = 1'b0;
        total++; if ({oError, oCpuReset, oDone, oBusy} !== 4'b1100) $display("FAIL bad_status: got %b want 1100", {oError, oCpuReset, oDone, oBusy}); else pass++;
        total++; if (wq.size() != 0) $display("FAIL bad_nwrites: got %0d want 0", wq.size()); else pass++;
        start_load();
        total++; if (oError !== 1'b0) $display("FAIL bad_errclear: got %b want 0", oError); else pass++;
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h12, 1); send_byte(8'h34, 0);
        wait_done(n);
        total++; if ({oDone, oCpuReset} !== 2'b10) $display("FAIL bad_recover: got %b want 10", {oDone, oCpuReset}); else pass++;
        total++; if (wq.size() != 1 || wq[0] !== {10'd0, 16'h1234}) $display("FAIL bad_recover_write: got n=%0d w=%h want 1 0001234", wq.size(), (wq.size() > 0) ? wq[0] : 26'd0); else pass++;
    endtask

    task automatic test_timeout();
        int n;
        wq.delete();
        start_load();
        send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'hAB, 0);
        n = 0;
        while (oError !== 1'b1 && n < 30) begin
            @(posedge Clock); #1;
            n++;
        end
        total++; if (n != 8) $display("FAIL timeout_cycles: got %0d want 8", n); else pass++;
        total++; if (oCpuReset !== 1'b1) $display("FAIL timeout_cpureset: got %b want 1", oCpuReset); else pass++;
        repeat (3) @(posedge Clock);
        #1;
        total++; if (wq.size() != 0) $display("FAIL timeout_nwrites: got %0d want 0", wq.size()); else pass++;
    endtask

    task automatic test_reset_mid();
        wq.delete();
        start_load();
        send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        total++; if ({oBusy, oDone, oError, oCpuReset} !== 4'b0001) $display("FAIL rstmid_status: got %b want 0001", {oBusy, oDone, oError, oCpuReset}); else pass++;
        total++; if ({bus.oAddress, bus.oDataOut} !== 26'd0) $display("FAIL rstmid_bus: got %h want 0", {bus.oAddress, bus.oDataOut}); else pass++;
        repeat (4) @(posedge Clock);
        #1;
        total++; if (wq.size() != 0) $display("FAIL rstmid_nwrites: got %0d want 0", wq.size()); else pass++;
        total++; if (bus.oByteReady !== 1'b0) $display("FAIL rstmid_ready: got %b want 0", bus.oByteReady); else pass++;
    endtask

    initial begin
        test_reset();
        test_three_words();
        test_backpressure(6);
        test_zero_count();
        test_bad_count();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
